decode_stage_sb: RTL and testbench
==================================

// Module: decode_stage_sb
// PURPOSE
//  Registered RV64I decode stage: extracts rd/rs1/rs2/opcode/funct fields, builds a sign-extended immediate and reads an internal register file with write-back bypass.
//  Sits between fetch and execute, with valid/ready handshakes on both sides.
//  A per-register pending-write scoreboard stalls RAW hazards until write-back.
// PARAMETERS
//  XLEN       64  data/PC width
//  NUM_REGS   32  architectural registers; RA_W = $clog2(NUM_REGS)
//  PEND_W     2   scoreboard counter width per register; max pending writes = 2**PEND_W-1
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  in_valid     in   1      fetch presents instruction
//  in_ready     out  1      decode accepts this cycle
//  in_instr     in   32     instruction bits
//  in_pc        in   XLEN   instruction PC
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      execute accepts bundle
//  out_pc       out  XLEN   registered PC
//  out_valA     out  XLEN   rs1 value (0 if rs1 unused)
//  out_valB     out  XLEN   rs2 value (0 if rs2 unused)
//  out_imm      out  XLEN   sign-extended immediate
//  out_rd       out  RA_W   destination register
//  out_rd_wen   out  1      instruction writes rd (rd!=0)
//  out_opcode   out  7      instr[6:0]
//  out_funct3   out  3      instr[14:12]
//  out_funct7   out  7      instr[31:25]
//  flush        in   1      squash bundle in output register; block acceptance
//  sb_clear     in   1      zero all scoreboard counters (pipeline fully drained)
//  wb_en        in   1      write-back valid
//  wb_rd        in   RA_W   write-back register
//  wb_data      in   XLEN   write-back data
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0, all out_* = 0, all registers and counters = 0. in_ready is 0 during reset.
//  Formats by opcode:
//   - LUI/AUIPC (U) and JAL (J): no sources.
//   - JALR, LOAD, OP-IMM, OP-IMM-32 (I): rs1 only.
//   - STORE (S), BRANCH (B): rs1 and rs2, no rd.
//   - OP, OP-32 (R): rs1 and rs2, imm=0.
//   - Unknown opcode: no sources, no rd, imm=0.
//   - Immediates sign-extend from bit 31 to XLEN. B and J immediates have bit0=0. U places imm[31:12] and zeroes [11:0].
//  x0 reads 0. Writes to x0 are ignored and never tracked; out_rd_wen=0 when rd=0.
//  Source hazard on rs (used, !=0) when any of:
//   - out_valid & out_rd_wen & out_rd==rs;
//   - cnt[rs]>1;
//   - cnt[rs]==1 and not (wb_en & wb_rd==rs) this cycle.
//  Saturation stall: rd_wen & cnt[rd]==2**PEND_W-1.
//  in_ready = reset & !flush & !hazard & !sat & (!out_valid | out_ready).
//  Accept (in_valid & in_ready): output register loads next edge. Latency is 1 cycle.
//  Operands are read at accept. Same-cycle wb_en to a source forwards wb_data, not the stale entry.
//  Output register: holds while out_valid & !out_ready.
//   - flush=1 clears out_valid next edge regardless of out_ready; no scoreboard change.
//  Scoreboard:
//   - cnt[out_rd]++ on output handshake (out_valid & out_ready & !flush & out_rd_wen).
//   - cnt[wb_rd]-- on wb_en & wb_rd!=0.
//   - Both on the same register in one cycle: net unchanged.
//   - Decrement at 0 stays 0; the register file write still happens.
//   - sb_clear has priority over both and zeroes all counters.
//  Register file: written at the rising edge when wb_en & wb_rd!=0.
// TESTING
//  1. Reset, then accept ADDI x1,x0,-5 @pc=0x100 -> next cycle out_valid=1, out_rd=1, out_imm=0xFFFF_FFFF_FFFF_FFFB, out_pc=0x100, out_valA=0.
//  2. Issue ADDI x2 (handshake), then ADD x3,x2,x2 -> in_ready=0 until wb_en/wb_rd=2/wb_data=0x55 arrives; that cycle accepts, out_valA=out_valB=0x55 (bypass).
//  3. Hold out_ready=0 for 4 cycles -> out_* stable, in_ready=0. Release -> exactly one handshake.
//  4. SW x5,-8(x6) -> out_rd_wen=0, out_imm=-8. BEQ offset -4096 -> out_imm=0xFFFF_FFFF_FFFF_F000. LUI 0xABCDE -> out_imm=0xFFFF_FFFF_ABCD_E000.
//  5. Issue 3 writes to x7 (PEND_W=2) -> 4th x7 writer stalls. One wb to x7 in the same cycle as an issue -> cnt stays 3.
//  6. Assert reset mid-stall with out_valid=1 -> out_valid=0 immediately (async). Counters = 0; x5 reads 0 afterwards.

Source files
------------

// File: rtl/decode_stage_sb.sv
// RV64I decode stage: field extraction, immediate build and register-file read with
// write-back bypass, gated by a per-register pending-write scoreboard.
module decode_stage_sb #(
  parameter  int XLEN     = 64,
  parameter  int NUM_REGS = 32,
  parameter  int PEND_W   = 2,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_valA,
  output logic [XLEN-1:0] out_valB,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_rd,
  output logic            out_rd_wen,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  input  logic            flush,
  input  logic            sb_clear,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] r_cnt [NUM_REGS];
  logic [XLEN-1:0]   r_rf  [NUM_REGS];

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc, r_out_valA, r_out_valB, r_out_imm;
  logic [RA_W-1:0] r_out_rd;
  logic            r_out_rd_wen;
  logic [6:0]      r_out_opcode, r_out_funct7;
  logic [2:0]      r_out_funct3;

  logic [6:0]      w_opcode;
  logic [RA_W-1:0] w_rd;
  logic            w_use_rs1, w_use_rs2, w_has_rd, w_rd_wen;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_wb_we, w_out_hs, w_sat, w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[7 +: RA_W];
  assign w_wb_we  = wb_en & (wb_rd != '0);
  assign w_out_hs = r_out_valid & out_ready & !flush;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_has_rd  = 1'b0;
    w_imm32   = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        w_has_rd = 1'b1;
        w_imm32  = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_has_rd = 1'b1;
        w_imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
        w_use_rs1 = 1'b1;
        w_has_rd  = 1'b1;
        w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      OP_OP, OP_OP32: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_has_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_imm    = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  assign w_rd_wen = w_has_rd & (w_rd != '0);

  // Per-source hazard and operand read; a write-back landing this cycle both
  // retires the last pending write and supplies the operand value.
  logic [RA_W-1:0] w_src     [2];
  logic [XLEN-1:0] w_src_val [2];
  logic [1:0]      w_src_use;
  logic [1:0]      w_src_haz;

  assign w_src[0]  = in_instr[15 +: RA_W];
  assign w_src[1]  = in_instr[20 +: RA_W];
  assign w_src_use = {w_use_rs2, w_use_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [PEND_W-1:0] w_cnt;
      logic              w_live;
      logic              w_wb_hit;
      assign w_cnt    = r_cnt[w_src[gi]];
      assign w_live   = w_src_use[gi] & (w_src[gi] != '0);
      assign w_wb_hit = w_wb_we & (wb_rd == w_src[gi]);
      assign w_src_haz[gi] = w_live &
          ((r_out_valid & r_out_rd_wen & (r_out_rd == w_src[gi])) |
           (w_cnt > PEND_W'(1)) |
           ((w_cnt == PEND_W'(1)) & !w_wb_hit));
      assign w_src_val[gi] = !w_live ? '0 : (w_wb_hit ? wb_data : r_rf[w_src[gi]]);
    end
  endgenerate

  assign w_sat    = w_rd_wen & (r_cnt[w_rd] == CNT_MAX);
  assign in_ready = reset & !flush & !(|w_src_haz) & !w_sat & (!r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_out_valA   <= '0;
      r_out_valB   <= '0;
      r_out_imm    <= '0;
      r_out_rd     <= '0;
      r_out_rd_wen <= 1'b0;
      r_out_opcode <= '0;
      r_out_funct3 <= '0;
      r_out_funct7 <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_pc     <= in_pc;
      r_out_valA   <= w_src_val[0];
      r_out_valB   <= w_src_val[1];
      r_out_imm    <= w_imm;
      r_out_rd     <= w_has_rd ? w_rd : '0;
      r_out_rd_wen <= w_rd_wen;
      r_out_opcode <= w_opcode;
      r_out_funct3 <= in_instr[14:12];
      r_out_funct7 <= in_instr[31:25];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  logic [NUM_REGS-1:0] w_cnt_inc, w_cnt_dec;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      assign w_cnt_inc[gi] = w_out_hs & r_out_rd_wen & (r_out_rd == RA_W'(gi));
      assign w_cnt_dec[gi] = w_wb_we & (wb_rd == RA_W'(gi));
    end
  endgenerate

  // Issue and retire on the same register cancel; retire at zero is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else if (sb_clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_cnt_inc[i] & !w_cnt_dec[i])
          r_cnt[i] <= r_cnt[i] + PEND_W'(1);
        else if (w_cnt_dec[i] & !w_cnt_inc[i] & (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_valA   = r_out_valA;
  assign out_valB   = r_out_valB;
  assign out_imm    = r_out_imm;
  assign out_rd     = r_out_rd;
  assign out_rd_wen = r_out_rd_wen;
  assign out_opcode = r_out_opcode;
  assign out_funct3 = r_out_funct3;
  assign out_funct7 = r_out_funct7;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Bench for decode_stage_sb: directed scenarios plus randomized traffic compared
// cycle by cycle against a behavioural model of decode, scoreboard and register file.
module tb_decode_stage_sb;

  localparam int NR   = 32;
  localparam int PMAX = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, sb_clear = 1'b0, wb_en = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0;
  logic        in_ready, out_valid, out_rd_wen;
  logic [63:0] out_pc, out_valA, out_valB, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  decode_stage_sb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_valA(out_valA), .out_valB(out_valB), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .flush(flush), .sb_clear(sb_clear),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [63:0] m_rf [NR];
  int          m_cnt [NR];
  bit          m_valid, m_rd_wen, m_acc;
  logic [63:0] m_pc, m_va, m_vb, m_imm;
  int          m_rd;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;

  typedef struct {
    bit          has_rd;
    int          rs1, rs2, rd;
    logic [63:0] imm;
  } dec_t;

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_rf[r] = '0;
      m_cnt[r] = 0;
    end
    m_valid = 0; m_rd_wen = 0; m_acc = 0;
    m_pc = '0; m_va = '0; m_vb = '0; m_imm = '0; m_rd = 0;
    m_op = '0; m_f7 = '0; m_f3 = '0;
  endtask

  // Two's-complement value of the low 'bits' bits of v
  function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
    longint r;
    r = longint'(v) & ((longint'(1) << bits) - 1);
    if (v[bits-1]) r = r - (longint'(1) << bits);
    return r;
  endfunction

  // Unused sources are reported as x0, which reads 0 and never hazards
  function automatic dec_t m_decode(input logic [31:0] ins);
    dec_t d;
    bit u1, u2;
    d.has_rd = 0; d.imm = '0; u1 = 0; u2 = 0;
    d.rs1 = int'(ins[19:15]);
    d.rs2 = int'(ins[24:20]);
    d.rd  = int'(ins[11:7]);
    case (ins[6:0])
      7'h37, 7'h17: begin d.has_rd = 1; d.imm = sx({ins[31:12], 12'h000}, 32); end
      7'h6F: begin d.has_rd = 1; d.imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); end
      7'h67, 7'h03, 7'h13, 7'h1B: begin u1 = 1; d.has_rd = 1; d.imm = sx(ins[31:20], 12); end
      7'h23: begin u1 = 1; u2 = 1; d.imm = sx({ins[31:25], ins[11:7]}, 12); end
      7'h63: begin u1 = 1; u2 = 1; d.imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13); end
      7'h33, 7'h3B: begin u1 = 1; u2 = 1; d.has_rd = 1; end
      default: ;
    endcase
    if (!u1) d.rs1 = 0;
    if (!u2) d.rs2 = 0;
    return d;
  endfunction

  function automatic bit m_src_haz(input int rs);
    if (rs == 0) return 0;
    if (m_valid && m_rd_wen && m_rd == rs) return 1;
    if (m_cnt[rs] > 1) return 1;
    if (m_cnt[rs] == 1 && !(wb_en && int'(wb_rd) == rs)) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] m_read(input int rs);
    if (rs == 0) return '0;
    if (wb_en && int'(wb_rd) == rs) return wb_data;
    return m_rf[rs];
  endfunction

  // One clock: check in_ready against the model, advance model, check outputs after the edge
  task automatic step();
    dec_t d;
    bit rdy, hs, inc, dec;
    logic [63:0] va, vb;
    #1;
    d   = m_decode(in_instr);
    rdy = !flush && !m_src_haz(d.rs1) && !m_src_haz(d.rs2) &&
          !(d.has_rd && d.rd != 0 && m_cnt[d.rd] == PMAX - 1) && (!m_valid || out_ready);
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    m_acc = in_valid && rdy;
    va = m_read(d.rs1);
    vb = m_read(d.rs2);
    hs = m_valid && out_ready && !flush;
    for (int r = 0; r < NR; r++) begin
      if (sb_clear) m_cnt[r] = 0;
      else begin
        inc = hs && m_rd_wen && m_rd == r;
        dec = wb_en && int'(wb_rd) == r && r != 0;
        if (inc && !dec) m_cnt[r] = (m_cnt[r] + 1) % PMAX;
        else if (dec && !inc && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
      end
    end
    if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    if (flush) m_valid = 0;
    else if (m_acc) begin
      m_valid = 1; m_pc = in_pc; m_va = va; m_vb = vb; m_imm = d.imm;
      m_rd = d.rd; m_rd_wen = d.has_rd && d.rd != 0;
      m_op = in_instr[6:0]; m_f3 = in_instr[14:12]; m_f7 = in_instr[31:25];
    end else if (out_ready) m_valid = 0;
    @(posedge clk);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_valA", out_valA, m_va);
      check("out_valB", out_valB, m_vb);
      check("out_imm", out_imm, m_imm);
      check("out_rd_wen", {63'd0, out_rd_wen}, {63'd0, m_rd_wen});
      check("out_opcode", {57'd0, out_opcode}, {57'd0, m_op});
      check("out_funct3", {61'd0, out_funct3}, {61'd0, m_f3});
      check("out_funct7", {57'd0, out_funct7}, {57'd0, m_f7});
      if (m_rd_wen) check("out_rd", {59'd0, out_rd}, 64'(m_rd));
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc, output int cycles);
    cycles = 0;
    in_valid = 1; in_instr = ins; in_pc = pc;
    do begin
      step();
      cycles++;
    end while (!m_acc && cycles < 20);
    if (!m_acc) check("issue_timeout", {63'd0, m_acc}, 64'd1);
    in_valid = 0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                           7'h1B, 7'h23, 7'h63, 7'h33, 7'h3B, 7'h7F};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] ins;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_rd_wen", {63'd0, out_rd_wen}, 64'd0);
    reset = 1;
    out_ready = 1;

    // ADDI x1,x0,-5
    issue(enc_i(12'hFFB, 5'd0, 5'd1), 64'h100, cyc);
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_rd", {59'd0, out_rd}, 64'd1);
    check("t1_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFB);
    check("t1_pc", out_pc, 64'h100);
    check("t1_valA", out_valA, 64'd0);

    // RAW on x2 resolved by write-back bypass
    issue(enc_i(12'd7, 5'd0, 5'd2), 64'h104, cyc);
    in_valid = 1; in_instr = enc_r(5'd2, 5'd2, 5'd3); in_pc = 64'h108;
    step();
    step();
    check("t2_stall", {63'd0, in_ready}, 64'd0);
    wb_en = 1; wb_rd = 5'd2; wb_data = 64'h55;
    step();
    check("t2_accept", {63'd0, m_acc}, 64'd1);
    wb_en = 0; in_valid = 0;
    check("t2_valA", out_valA, 64'h55);
    check("t2_valB", out_valB, 64'h55);

    // Backpressure hold
    issue(enc_i(12'd3, 5'd0, 5'd4), 64'h110, cyc);
    out_ready = 0;
    in_valid = 1; in_instr = {20'h12345, 5'd9, 7'h37}; in_pc = 64'h118;
    repeat (4) begin
      step();
      check("t3_hold_ready", {63'd0, in_ready}, 64'd0);
      check("t3_hold_pc", out_pc, 64'h110);
    end
    in_valid = 0; out_ready = 1;
    step();
    check("t3_release", {63'd0, out_valid}, 64'd0);

    // Immediate formats
    issue(enc_s(12'hFF8, 5'd5, 5'd6), 64'h200, cyc);
    check("t4_sw_wen", {63'd0, out_rd_wen}, 64'd0);
    check("t4_sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    issue(enc_b(13'h1000, 5'd0, 5'd0), 64'h204, cyc);
    check("t4_beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_F000);
    issue({20'hABCDE, 5'd9, 7'h37}, 64'h208, cyc);
    check("t4_lui_imm", out_imm, 64'hFFFF_FFFF_ABCD_E000);

    // Scoreboard saturation on x7; W4 handshake coincides with a write-back
    for (int k = 0; k < 4; k++) issue(enc_i(12'(k), 5'd0, 5'd7), 64'h300 + 64'(4 * k), cyc);
    in_valid = 1; in_instr = enc_i(12'd9, 5'd0, 5'd7); in_pc = 64'h310;
    wb_en = 1; wb_rd = 5'd7; wb_data = 64'h77;
    step();
    check("t5_sat_first", {63'd0, in_ready}, 64'd0);
    wb_en = 0;
    repeat (3) begin
      step();
      check("t5_sat_stall", {63'd0, in_ready}, 64'd0);
    end

    // Async reset during a stall with a bundle held
    in_valid = 0;
    wb_en = 1; wb_rd = 5'd5; wb_data = 64'h1234;
    step();
    wb_en = 0;
    out_ready = 0;
    issue(enc_i(12'd1, 5'd0, 5'd8), 64'h400, cyc);
    in_valid = 1; in_instr = enc_r(5'd8, 5'd5, 5'd10); in_pc = 64'h404;
    step();
    step();
    #2;
    reset = 0;
    #1;
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_ready", {63'd0, in_ready}, 64'd0);
    check("t6_rst_pc", out_pc, 64'd0);
    m_reset();
    in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1;
    reset = 1;
    issue(enc_r(5'd7, 5'd5, 5'd10), 64'h500, cyc);
    check("t6_no_stall", 64'(cyc), 64'd1);
    check("t6_x5_zero", out_valA, 64'd0);
    issue(enc_i(12'd2, 5'd0, 5'd7), 64'h504, cyc);
    check("t6_x7_free", 64'(cyc), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      in_instr  = ins;
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 25) == 0;
      sb_clear  = ($urandom % 50) == 0;
      wb_en     = ($urandom % 3) == 0;
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
